decode_stage: RTL and testbench

Registered, handshaked instruction-decode stage for the MIPS core. It decodes one 32-bit instruction word per transfer into the control bundle consumed by the register file, ALU and memory stage, plus decoded register indices and an extended immediate. It is the pipelined successor of the combinational decoder. It adds an optional extended opcode set, an illegal-instruction flag, a valid/ready output register, a load-use interlock and a flush input. It sits between fetch and execute.

---
 rtl/decode_stage.sv | 217 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered, handshaked MIPS instruction decoder with optional extended opcodes,
// illegal-instruction flag, load-use interlock and flush.
`timescale 1ns/1ps
module decode_stage #(
  parameter bit EXT_ISA        = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_write_reg,
  output logic        out_write_mem,
  output logic        out_use_imm,
  output logic        out_read_ram,
  output logic        out_branch,
  output logic        out_branch_eq,
  output logic [1:0]  out_dst_reg,
  output logic [1:0]  out_jmp,
  output logic [3:0]  out_alu_ctrl,
  output logic        out_illegal,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic [31:0] out_target,
  output logic [31:0] out_pc4
);

  localparam logic [3:0] CTRL_ADDU    = 4'd0;
  localparam logic [3:0] CTRL_OR      = 4'd1;
  localparam logic [3:0] CTRL_ADDIU   = 4'd2;
  localparam logic [3:0] CTRL_SW      = 4'd3;
  localparam logic [3:0] CTRL_LW      = 4'd4;
  localparam logic [3:0] CTRL_BNE     = 4'd5;
  localparam logic [3:0] CTRL_J       = 4'd6;
  localparam logic [3:0] CTRL_JAL     = 4'd7;
  localparam logic [3:0] CTRL_BEQ     = 4'd8;
  localparam logic [3:0] CTRL_ORI     = 4'd9;
  localparam logic [3:0] CTRL_LUI     = 4'd10;
  localparam logic [3:0] CTRL_SLT     = 4'd11;
  localparam logic [3:0] CTRL_SLL     = 4'd12;
  localparam logic [3:0] CTRL_JR      = 4'd13;
  localparam logic [3:0] CTRL_INVALID = 4'd15;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  logic [5:0]  op, fn;
  logic        wr_p0, wm_p0, ui_p0, rr_p0, br_p0, beq_p0, ill_p0;
  logic        use_rs_p0, use_rt_p0, hazard;
  logic [1:0]  dst_p0, jmp_p0;
  logic [3:0]  alu_p0;
  logic [31:0] imm_p0;

  assign op = in_instr[31:26];
  assign fn = in_instr[5:0];

  // p0: combinational decode of the offered word
  always_comb begin
    wr_p0     = 1'b0;
    wm_p0     = 1'b0;
    ui_p0     = 1'b0;
    rr_p0     = 1'b0;
    br_p0     = 1'b0;
    beq_p0    = 1'b0;
    dst_p0    = 2'b00;
    jmp_p0    = 2'b00;
    alu_p0    = CTRL_INVALID;
    ill_p0    = 1'b1;
    imm_p0    = 32'h0;
    use_rs_p0 = 1'b0;
    use_rt_p0 = 1'b0;
    case (op)
      OP_R: begin
        case (fn)
          FN_ADDU, FN_OR: begin
            wr_p0 = 1'b1; dst_p0 = 2'b01; ill_p0 = 1'b0;
            use_rs_p0 = 1'b1; use_rt_p0 = 1'b1;
            alu_p0 = (fn == FN_ADDU) ? CTRL_ADDU : CTRL_OR;
          end
          FN_SLT: if (EXT_ISA) begin
            wr_p0 = 1'b1; dst_p0 = 2'b01; ill_p0 = 1'b0;
            use_rs_p0 = 1'b1; use_rt_p0 = 1'b1; alu_p0 = CTRL_SLT;
          end
          FN_SLL: if (EXT_ISA) begin
            wr_p0 = 1'b1; dst_p0 = 2'b01; ill_p0 = 1'b0;
            use_rt_p0 = 1'b1; alu_p0 = CTRL_SLL;
            imm_p0 = {27'h0, in_instr[10:6]};
          end
          FN_JR: if (EXT_ISA) begin
            jmp_p0 = 2'b11; ill_p0 = 1'b0;
            use_rs_p0 = 1'b1; use_rt_p0 = 1'b1; alu_p0 = CTRL_JR;
          end
          default: ;
        endcase
      end
      OP_ADDIU: begin
        wr_p0 = 1'b1; ui_p0 = 1'b1; ill_p0 = 1'b0; use_rs_p0 = 1'b1;
        alu_p0 = CTRL_ADDIU; imm_p0 = sext16(in_instr[15:0]);
      end
      OP_LW: begin
        wr_p0 = 1'b1; ui_p0 = 1'b1; rr_p0 = 1'b1; ill_p0 = 1'b0; use_rs_p0 = 1'b1;
        alu_p0 = CTRL_LW; imm_p0 = sext16(in_instr[15:0]);
      end
      OP_SW: begin
        wm_p0 = 1'b1; ui_p0 = 1'b1; ill_p0 = 1'b0;
        use_rs_p0 = 1'b1; use_rt_p0 = 1'b1;
        alu_p0 = CTRL_SW; imm_p0 = sext16(in_instr[15:0]);
      end
      OP_BNE: begin
        br_p0 = 1'b1; ill_p0 = 1'b0; use_rs_p0 = 1'b1; use_rt_p0 = 1'b1;
        alu_p0 = CTRL_BNE; imm_p0 = sext16(in_instr[15:0]);
      end
      OP_J: begin
        jmp_p0 = 2'b10; ill_p0 = 1'b0; alu_p0 = CTRL_J;
      end
      OP_JAL: begin
        wr_p0 = 1'b1; dst_p0 = 2'b10; jmp_p0 = 2'b01; ill_p0 = 1'b0; alu_p0 = CTRL_JAL;
      end
      OP_BEQ: if (EXT_ISA) begin
        br_p0 = 1'b1; beq_p0 = 1'b1; ill_p0 = 1'b0;
        use_rs_p0 = 1'b1; use_rt_p0 = 1'b1;
        alu_p0 = CTRL_BEQ; imm_p0 = sext16(in_instr[15:0]);
      end
      OP_ORI: if (EXT_ISA) begin
        wr_p0 = 1'b1; ui_p0 = 1'b1; ill_p0 = 1'b0; use_rs_p0 = 1'b1;
        alu_p0 = CTRL_ORI; imm_p0 = zext16(in_instr[15:0]);
      end
      OP_LUI: if (EXT_ISA) begin
        wr_p0 = 1'b1; ui_p0 = 1'b1; ill_p0 = 1'b0;
        alu_p0 = CTRL_LUI; imm_p0 = {in_instr[15:0], 16'h0000};
      end
      default: ;
    endcase
  end

  // Only lw raises out_read_ram, so it identifies a held load.
  assign hazard = LOAD_USE_STALL && out_valid && out_read_ram && (out_rt != 5'd0) &&
                  ((use_rs_p0 && (in_instr[25:21] == out_rt)) ||
                   (use_rt_p0 && (in_instr[20:16] == out_rt)));

  assign in_ready = !flush && !hazard && (!out_valid || out_ready);

  // p1: output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_write_reg <= 1'b0;
      out_write_mem <= 1'b0;
      out_use_imm   <= 1'b0;
      out_read_ram  <= 1'b0;
      out_branch    <= 1'b0;
      out_branch_eq <= 1'b0;
      out_dst_reg   <= 2'b00;
      out_jmp       <= 2'b00;
      out_alu_ctrl  <= CTRL_INVALID;
      out_illegal   <= 1'b0;
      out_rs        <= 5'd0;
      out_rt        <= 5'd0;
      out_rd        <= 5'd0;
      out_imm       <= 32'h0;
      out_target    <= 32'h0;
      out_pc4       <= 32'h0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid     <= 1'b1;
      out_write_reg <= wr_p0;
      out_write_mem <= wm_p0;
      out_use_imm   <= ui_p0;
      out_read_ram  <= rr_p0;
      out_branch    <= br_p0;
      out_branch_eq <= beq_p0;
      out_dst_reg   <= dst_p0;
      out_jmp       <= jmp_p0;
      out_alu_ctrl  <= alu_p0;
      out_illegal   <= ill_p0;
      out_rs        <= in_instr[25:21];
      out_rt        <= in_instr[20:16];
      out_rd        <= in_instr[15:11];
      out_imm       <= imm_p0;
      out_target    <= {in_pc4[31:28], in_instr[25:0], 2'b00};
      out_pc4       <= in_pc4;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three parameter variants share one stimulus stream and
// are checked each cycle against a mnemonic-level model plus literal expectations.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam int M_ADDU = 0, M_OR = 1, M_ADDIU = 2, M_SW = 3, M_LW = 4, M_BNE = 5,
                 M_J = 6, M_JAL = 7, M_BEQ = 8, M_ORI = 9, M_LUI = 10, M_SLT = 11,
                 M_SLL = 12, M_JR = 13, M_ILL = 15;

  typedef struct packed {
    logic        wr, wm, ui, rr, br, beq;
    logic [1:0]  dst, jmp;
    logic [3:0]  alu;
    logic        ill;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, target, pc4;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc4 = 32'h0;
  logic        out_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dec_t got [3];
  logic ov [3];
  logic ir [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic        r, v, wr, wm, ui, rr, br, beq, ill;
    logic [1:0]  dst, jmp;
    logic [3:0]  alu;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, target, pc4;
    decode_stage #(.EXT_ISA(g != 2), .LOAD_USE_STALL(g != 1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r),
      .in_instr(in_instr), .in_pc4(in_pc4), .out_valid(v), .out_ready(out_ready),
      .out_write_reg(wr), .out_write_mem(wm), .out_use_imm(ui), .out_read_ram(rr),
      .out_branch(br), .out_branch_eq(beq), .out_dst_reg(dst), .out_jmp(jmp),
      .out_alu_ctrl(alu), .out_illegal(ill), .out_rs(rs), .out_rt(rt), .out_rd(rd),
      .out_imm(imm), .out_target(target), .out_pc4(pc4)
    );
    assign got[g] = {wr, wm, ui, rr, br, beq, dst, jmp, alu, ill, rs, rt, rd, imm, target, pc4};
    assign ov[g]  = v;
    assign ir[g]  = r;
  end

  function automatic int mnem(input logic [31:0] i, input bit ext);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'd0) begin
      if (fn == 6'b100001) return M_ADDU;
      if (fn == 6'b100101) return M_OR;
      if (ext && fn == 6'b101010) return M_SLT;
      if (ext && fn == 6'b000000) return M_SLL;
      if (ext && fn == 6'b001000) return M_JR;
      return M_ILL;
    end
    if (op == 6'b001001) return M_ADDIU;
    if (op == 6'b101011) return M_SW;
    if (op == 6'b100011) return M_LW;
    if (op == 6'b000101) return M_BNE;
    if (op == 6'b000010) return M_J;
    if (op == 6'b000011) return M_JAL;
    if (ext && op == 6'b000100) return M_BEQ;
    if (ext && op == 6'b001101) return M_ORI;
    if (ext && op == 6'b001111) return M_LUI;
    return M_ILL;
  endfunction

  function automatic dec_t model_dec(input logic [31:0] i, input logic [31:0] pc4, input bit ext);
    dec_t d;
    int m;
    logic [31:0] se;
    m = mnem(i, ext);
    se = {{16{i[15]}}, i[15:0]};
    d = '0;
    d.alu = 4'(m);
    d.rs = i[25:21]; d.rt = i[20:16]; d.rd = i[15:11];
    d.target = {pc4[31:28], i[25:0], 2'b00};
    d.pc4 = pc4;
    case (m)
      M_ADDU, M_OR, M_SLT: begin d.wr = 1; d.dst = 2'b01; end
      M_SLL:   begin d.wr = 1; d.dst = 2'b01; d.imm = 32'(i[10:6]); end
      M_JR:    d.jmp = 2'b11;
      M_ADDIU: begin d.wr = 1; d.ui = 1; d.imm = se; end
      M_LW:    begin d.wr = 1; d.ui = 1; d.rr = 1; d.imm = se; end
      M_SW:    begin d.wm = 1; d.ui = 1; d.imm = se; end
      M_BNE:   begin d.br = 1; d.imm = se; end
      M_BEQ:   begin d.br = 1; d.beq = 1; d.imm = se; end
      M_J:     d.jmp = 2'b10;
      M_JAL:   begin d.wr = 1; d.dst = 2'b10; d.jmp = 2'b01; end
      M_ORI:   begin d.wr = 1; d.ui = 1; d.imm = {16'h0, i[15:0]}; end
      M_LUI:   begin d.wr = 1; d.ui = 1; d.imm = {i[15:0], 16'h0}; end
      default: d.ill = 1;
    endcase
    return d;
  endfunction

  function automatic bit reads(input logic [31:0] i, input bit ext, input logic [4:0] r);
    int m;
    bit rs_used, rt_used;
    if (r == 5'd0) return 0;
    m = mnem(i, ext);
    rs_used = m inside {M_ADDU, M_OR, M_SLT, M_JR, M_ADDIU, M_ORI, M_LW, M_SW, M_BEQ, M_BNE};
    rt_used = m inside {M_ADDU, M_OR, M_SLT, M_SLL, M_JR, M_SW, M_BEQ, M_BNE};
    return (rs_used && i[25:21] == r) || (rt_used && i[20:16] == r);
  endfunction

  bit          ext_p [3] = '{1'b1, 1'b1, 1'b0};
  bit          lus_p [3] = '{1'b1, 1'b0, 1'b1};
  bit          mv [3];
  dec_t        md [3];
  logic [31:0] mi [3];

  function automatic bit model_ready(input bit v, input logic [31:0] held, input bit ext, input bit lus);
    bit hz;
    hz = lus && v && (mnem(held, ext) == M_LW) && reads(in_instr, ext, held[20:16]);
    return !flush && !hz && (!v || out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        mv[g] <= 1'b0;
        md[g] <= '{alu: 4'd15, default: '0};
        mi[g] <= 32'h0;
      end else if (flush) begin
        mv[g] <= 1'b0;
      end else if (in_valid && model_ready(mv[g], mi[g], ext_p[g], lus_p[g])) begin
        mv[g] <= 1'b1;
        md[g] <= model_dec(in_instr, in_pc4, ext_p[g]);
        mi[g] <= in_instr;
      end else if (out_ready) begin
        mv[g] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      bit er;
      er = model_ready(mv[g], mi[g], ext_p[g], lus_p[g]);
      n_cmp++;
      if (ir[g] !== er) begin
        n_fail++;
        $display("FAIL in_ready[%0d] t=%0t got %b expected %b", g, $time, ir[g], er);
      end
      n_cmp++;
      if (ov[g] !== mv[g]) begin
        n_fail++;
        $display("FAIL out_valid[%0d] t=%0t got %b expected %b", g, $time, ov[g], mv[g]);
      end
      n_cmp++;
      if (got[g] !== md[g]) begin
        n_fail++;
        $display("FAIL bundle[%0d] t=%0t got %h expected %h", g, $time, got[g], md[g]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = i;
    in_pc4   = pc;
  endtask

  logic [31:0] stream [12] = '{
    32'h00084080, 32'h0109482A, 32'h01000008, 32'h08100004,
    32'h0C100004, 32'h8C090000, 32'hAC090004, 32'h1509FFFE,
    32'hFC000000, 32'h8C000000, 32'h00004821, 32'h01094825
  };

  initial begin
    dec_t t;
    tick();
    tick();
    chk("reset_valid", 32'(ov[0]), 32'h0);
    chk("reset_alu", 32'(got[0].alu), 32'hF);
    chk("reset_imm", got[0].imm, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;

    t = model_dec(32'h24080005, 32'h0, 1'b1);
    chk("model_addiu_imm", t.imm, 32'h5);
    t = model_dec(32'h3C01ABCD, 32'h0, 1'b1);
    chk("model_lui_imm", t.imm, 32'hABCD0000);
    t = model_dec(32'h10220003, 32'h0, 1'b0);
    chk("model_beq_base_ill", 32'(t.ill), 32'h1);
    t = model_dec(32'h01094821, 32'h0, 1'b1);
    chk("model_addu_dst", 32'(t.dst), 32'h1);

    offer(32'h24080005, 32'h00400004);
    tick();
    chk("addiu_valid", 32'(ov[0]), 32'h1);
    chk("addiu_imm", got[0].imm, 32'h5);
    chk("addiu_dst", 32'(got[0].dst), 32'h0);
    chk("addiu_alu", 32'(got[0].alu), 32'h2);
    offer(32'h01094821, 32'h00400008);
    tick();
    chk("addu_valid", 32'(ov[0]), 32'h1);
    chk("addu_dst", 32'(got[0].dst), 32'h1);
    chk("addu_rd", 32'(got[0].rd), 32'd9);
    in_valid = 1'b0;
    tick();

    offer(32'h8C080000, 32'h0040000C);
    tick();
    offer(32'h01004821, 32'h00400010);
    #1;
    chk("lu_stall_ready", 32'(ir[0]), 32'h0);
    chk("lu_nostall_ready", 32'(ir[1]), 32'h1);
    tick();
    chk("lu_bubble", 32'(ov[0]), 32'h0);
    chk("lu_nostall_valid", 32'(ov[1]), 32'h1);
    chk("lu_nostall_alu", 32'(got[1].alu), 32'h0);
    tick();
    chk("lu_after_valid", 32'(ov[0]), 32'h1);
    chk("lu_after_alu", 32'(got[0].alu), 32'h0);
    in_valid = 1'b0;
    tick();

    offer(32'h3C01ABCD, 32'h00400014);
    tick();
    chk("lui_imm", got[0].imm, 32'hABCD0000);
    offer(32'h3421FFFF, 32'h00400018);
    tick();
    chk("ori_imm", got[0].imm, 32'h0000FFFF);
    offer(32'h2421FFFF, 32'h0040001C);
    tick();
    chk("addiu_neg_imm", got[0].imm, 32'hFFFFFFFF);
    offer(32'h10220003, 32'h00400020);
    tick();
    chk("beq_branch", 32'(got[0].br), 32'h1);
    chk("beq_eq", 32'(got[0].beq), 32'h1);
    chk("beq_base_ill", 32'(got[2].ill), 32'h1);
    chk("beq_base_branch", 32'(got[2].br), 32'h0);
    chk("beq_base_alu", 32'(got[2].alu), 32'hF);

    for (int k = 0; k < 12; k++) begin
      offer(stream[k], 32'hA0000000 + 32'(k * 4));
      tick();
    end
    in_valid = 1'b0;
    tick();

    offer(32'h24080005, 32'h00400024);
    tick();
    out_ready = 1'b0;
    in_instr = 32'h24090007;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", 32'(ov[0]), 32'h1);
      chk("bp_imm", got[0].imm, 32'h5);
      chk("bp_ready", 32'(ir[0]), 32'h0);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_ready", 32'(ir[0]), 32'h0);
    tick();
    chk("flush_valid", 32'(ov[0]), 32'h0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();

    offer(32'h24080005, 32'h00400028);
    tick();
    chk("pre_rst_valid", 32'(ov[0]), 32'h1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ov[0]), 32'h0);
    chk("async_rst_alu", 32'(got[0].alu), 32'hF);
    #1 rst = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
